// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one external ALU between two requesters, with a registered tagged response.
// Optional macro ALU_SHARE_OPCHK_EN flags opcodes above 3'b101 as errors and returns a zero result for them.
module alu_share_ctrl #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic last_grant_q, last_grant_d, id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, rsp_result_q, rsp_result_d;
  logic [CTRL_W-1:0] op_q, op_d;
  logic rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_id_d, rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;
  logic g0, g1, illegal;
  always_comb begin
`ifdef ALU_SHARE_OPCHK_EN
    illegal = op_q > CTRL_W'(5);
`else
    illegal = 1'b0;
`endif
    // last_grant_q=1 means requester 0 wins the next tie
    g0 = state_q == IDLE && !rst && req0_valid && (!req1_valid || last_grant_q);
    g1 = state_q == IDLE && !rst && req1_valid && (!req0_valid || !last_grant_q);
    state_d = state_q;
    last_grant_d = last_grant_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      IDLE: if (g0 || g1) begin
        a_d = g1 ? req1_a : req0_a;
        b_d = g1 ? req1_b : req0_b;
        op_d = g1 ? req1_op : req0_op;
        id_d = g1;
        last_grant_d = g1;
        state_d = EXEC;
      end
      EXEC: begin
        rsp_valid_d = 1'b1;
        rsp_id_d = id_q;
        rsp_result_d = illegal ? '0 : alu_result;
        rsp_zero_d = !illegal && alu_zero;
        rsp_err_d = illegal;
        state_d = RESP;
      end
      default: if (rsp_ready) begin
        rsp_valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_grant_q <= 1'b1;
      id_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_grant_q <= last_grant_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q <= rsp_err_d;
    end
  end
  assign req0_ready = g0;
  assign req1_ready = g1;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = (state_q == EXEC && illegal) ? '0 : op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err = rsp_err_q;
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of alu_share_ctrl against a behavioural ALU.
module tb_alu_share_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 0, req0_ready, req1_valid = 0, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0] alu_op;
  logic alu_zero, rsp_valid, rsp_ready = 0, rsp_id, rsp_zero, rsp_err;
  int compared = 0, mismatched = 0;

  alu_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      3'd0: alu_result = alu_a + alu_b;
      3'd1: alu_result = alu_a - alu_b;
      3'd2: alu_result = alu_a & alu_b;
      3'd3: alu_result = alu_a | alu_b;
      3'd4: alu_result = alu_a ^ alu_b;
      3'd5: alu_result = {31'b0, $signed(alu_a) < $signed(alu_b)};
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    alu_zero = alu_result == 32'd0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    req0_valid = 1;
    tick();
    chk("rst_ready0", {31'b0, req0_ready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_rsp_result", rsp_result, 0);
    chk("rst_alu_a", alu_a, 0);
    rst = 0;
    req0_a = 7; req0_b = 5; req0_op = 3'd0; rsp_ready = 1;
    #1;
    chk("add_ready0", {31'b0, req0_ready}, 1);
    chk("add_ready1", {31'b0, req1_ready}, 0);
    tick();
    req0_valid = 0;
    chk("add_exec_alu_a", alu_a, 7);
    chk("add_exec_ready0", {31'b0, req0_ready}, 0);
    chk("add_exec_rsp_valid", {31'b0, rsp_valid}, 0);
    tick();
    chk("add_rsp_valid", {31'b0, rsp_valid}, 1);
    chk("add_rsp_id", {31'b0, rsp_id}, 0);
    chk("add_rsp_result", rsp_result, 12);
    chk("add_rsp_zero", {31'b0, rsp_zero}, 0);
    tick();
    chk("add_idle_rsp_valid", {31'b0, rsp_valid}, 0);

    rst = 1; #1; rst = 0;
    req0_valid = 1; req0_a = 9; req0_b = 9; req0_op = 3'd1;
    req1_valid = 1; req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 3'd2;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk("rr_ready0", {31'b0, req0_ready}, (i % 2 == 0) ? 1 : 0);
      chk("rr_ready1", {31'b0, req1_ready}, (i % 2 == 1) ? 1 : 0);
      tick();
      tick();
      chk("rr_rsp_id", {31'b0, rsp_id}, i % 2);
      chk("rr_rsp_result", rsp_result, 0);
      chk("rr_rsp_zero", {31'b0, rsp_zero}, 1);
      tick();
    end
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'hFFFF_FFFD; req1_b = 2; req1_op = 3'd5; rsp_ready = 0;
    #1;
    chk("slt_ready1", {31'b0, req1_ready}, 1);
    tick();
    req1_valid = 0;
    tick();
    req0_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_rsp_valid", {31'b0, rsp_valid}, 1);
      chk("hold_rsp_result", rsp_result, 1);
      chk("hold_rsp_id", {31'b0, rsp_id}, 1);
      chk("hold_rsp_zero", {31'b0, rsp_zero}, 0);
      chk("hold_ready0", {31'b0, req0_ready}, 0);
      tick();
    end
    req0_valid = 0; rsp_ready = 1;
    tick();
    chk("hold_release", {31'b0, rsp_valid}, 0);

    req1_valid = 1; req1_a = 32'hF; req1_b = 3; req1_op = 3'd4;
    tick();
    req1_valid = 0;
    chk("xor_exec_alu_op", {29'b0, alu_op}, 4);
    rst = 1;
    #1;
    chk("mid_rst_alu_a", alu_a, 0);
    chk("mid_rst_alu_op", {29'b0, alu_op}, 0);
    chk("mid_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    tick();
    rst = 0;
    tick();
    tick();
    chk("post_rst_rsp_valid", {31'b0, rsp_valid}, 0);
    req0_valid = 1; req0_a = 100; req0_b = 1; req0_op = 3'd0;
    req1_valid = 1; req1_a = 1; req1_b = 1; req1_op = 3'd0;
    #1;
    chk("post_rst_ready0", {31'b0, req0_ready}, 1);
    chk("post_rst_ready1", {31'b0, req1_ready}, 0);
    tick();
    req0_valid = 0; req1_valid = 0; req0_a = 555;
    tick();
    chk("latched_rsp_result", rsp_result, 101);
    chk("latched_rsp_id", {31'b0, rsp_id}, 0);
    tick();

    req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 3'd7;
    tick();
    req0_valid = 0;
`ifdef ALU_SHARE_OPCHK_EN
    chk("ill_alu_op", {29'b0, alu_op}, 0);
    tick();
    chk("ill_rsp_err", {31'b0, rsp_err}, 1);
    chk("ill_rsp_result", rsp_result, 0);
`else
    chk("ill_alu_op", {29'b0, alu_op}, 7);
    tick();
    chk("ill_rsp_err", {31'b0, rsp_err}, 0);
    chk("ill_rsp_result", rsp_result, 32'hDEAD_BEEF);
`endif
    chk("ill_rsp_zero", {31'b0, rsp_zero}, 0);
    chk("ill_rsp_valid", {31'b0, rsp_valid}, 1);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
